tms_key_matrix: RTL and testbench

Keyboard matrix front-end that sits directly upstream of the tms1100 K inputs. It samples a raw 11x4 switch matrix and debounces every key. It rebuilds the 4-bit K value the CPU sees from whichever R strobe lines the CPU currently drives. It also emits a press/release event stream with a valid/ready handshake for a debug or host consumer.

---
 rtl/tms_key_matrix.sv | 131 +++++++++++++
 tb/tb_tms_key_matrix.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/tms_key_matrix.sv
// Keyboard matrix front-end for the tms1100 K inputs: 2-flop sync, per-key debounce,
// K rebuild from the active R strobes, and an optional press/release event stream (KEY_MATRIX_EVENT_EN).
module tms_key_matrix #(
    parameter int NUM_R    = 11,
    parameter int NUM_K    = 4,
    parameter int TICK_DIV = 3000,
    parameter int CODE_W   = 6
) (
    input  logic                   clk,
    input  logic                   button_reset,
    input  logic [NUM_R-1:0]       pins_r,
    input  logic [NUM_R*NUM_K-1:0] keys_raw,
    output logic [NUM_K-1:0]       pins_k,
    output logic                   event_valid,
    input  logic                   event_ready,
    output logic [CODE_W-1:0]      event_code,
    output logic                   event_pressed
);

    localparam int N  = NUM_R * NUM_K;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [N-1:0]  sync1;
    logic [N-1:0]  sync2;
    logic [PW-1:0] presc;
    logic          tick;
    logic [2:0]    hist [N];
    logic [N-1:0]  deb;
    logic [NUM_K-1:0] k_next;

    assign tick = (presc == PW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge button_reset) begin
        if (!button_reset) begin
            sync1 <= '0;
            sync2 <= '0;
            presc <= '0;
            deb   <= '0;
            for (int i = 0; i < N; i++) hist[i] <= 3'b000;
        end else begin
            sync1 <= keys_raw;
            sync2 <= sync1;
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) begin
                // Only the last three samples are kept; the fourth is the live synced bit.
                for (int i = 0; i < N; i++) begin
                    hist[i] <= {hist[i][1:0], sync2[i]};
                    if ({hist[i], sync2[i]} == 4'hf)
                        deb[i] <= 1'b1;
                    else if ({hist[i], sync2[i]} == 4'h0)
                        deb[i] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        k_next = '0;
        for (int k = 0; k < NUM_K; k++)
            for (int r = 0; r < NUM_R; r++)
                k_next[k] = k_next[k] | (pins_r[r] & deb[r*NUM_K + k]);
    end

    always_ff @(posedge clk or negedge button_reset) begin
        if (!button_reset) pins_k <= '0;
        else               pins_k <= k_next;
    end

`ifdef KEY_MATRIX_EVENT_EN
    // Handshake: an event is transferred on the rising edge where event_valid and
    // event_ready are both high; code/pressed hold steady while valid waits.
    typedef enum logic {SCAN, HOLD} scan_state_t;

    scan_state_t       state;
    scan_state_t       state_next;
    logic [CODE_W-1:0] idx;
    logic [N-1:0]      rep;
    logic              fire;
    logic              accept;

    always_comb begin
        state_next = state;
        fire       = 1'b0;
        accept     = 1'b0;
        case (state)
            SCAN: begin
                fire = (deb[idx] != rep[idx]);
                if (fire) state_next = HOLD;
            end
            HOLD: begin
                accept = event_valid & event_ready;
                if (accept) state_next = SCAN;
            end
            default: state_next = SCAN;
        endcase
    end

    always_ff @(posedge clk or negedge button_reset) begin
        if (!button_reset) state <= SCAN;
        else               state <= state_next;
    end

    always_ff @(posedge clk or negedge button_reset) begin
        if (!button_reset) begin
            idx           <= '0;
            rep           <= '0;
            event_valid   <= 1'b0;
            event_code    <= '0;
            event_pressed <= 1'b0;
        end else begin
            if (state == SCAN)
                idx <= (idx == CODE_W'(N - 1)) ? '0 : idx + 1'b1;
            if (fire) begin
                event_valid   <= 1'b1;
                event_code    <= idx;
                event_pressed <= deb[idx];
                rep[idx]      <= deb[idx];
            end
            if (accept)
                event_valid <= 1'b0;
        end
    end
`else
    logic unused_event_ready;
    assign unused_event_ready = event_ready;
    assign event_valid   = 1'b0;
    assign event_code    = '0;
    assign event_pressed = 1'b0;
`endif

endmodule

// File: tb/tb_tms_key_matrix.sv
// Directed bench for tms_key_matrix: pins_k checks in the stimulus thread, event
// expectations queued and popped by a separate handshake monitor.
module tb_tms_key_matrix;

    localparam int NUM_R = 11;
    localparam int NUM_K = 4;
    localparam int N     = NUM_R * NUM_K;
    localparam int CODE_W = 6;

    logic              clk = 1'b0;
    logic              button_reset;
    logic [NUM_R-1:0]  pins_r;
    logic [N-1:0]      keys_raw;
    logic [NUM_K-1:0]  pins_k;
    logic              event_valid;
    logic              event_ready;
    logic [CODE_W-1:0] event_code;
    logic              event_pressed;

    int n_cmp = 0;
    int n_bad = 0;
    logic [CODE_W:0] exp_q[$];
    logic prev_hs = 1'b0;

    tms_key_matrix #(.NUM_R(NUM_R), .NUM_K(NUM_K), .TICK_DIV(4), .CODE_W(CODE_W)) dut (
        .clk(clk), .button_reset(button_reset), .pins_r(pins_r), .keys_raw(keys_raw),
        .pins_k(pins_k), .event_valid(event_valid), .event_ready(event_ready),
        .event_code(event_code), .event_pressed(event_pressed)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int code, input bit pressed);
`ifdef KEY_MATRIX_EVENT_EN
        exp_q.push_back({pressed, CODE_W'(code)});
`endif
    endtask

    task automatic set_key(input int i, input bit v, input bit expect_event);
        @(posedge clk); #1;
        keys_raw[i] = v;
        if (expect_event) push_exp(i, v);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            cyc(1);
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    task automatic wait_valid(input string name);
`ifdef KEY_MATRIX_EVENT_EN
        int n = 0;
        while (!event_valid && n < 200) begin
            cyc(1);
            n++;
        end
        check(name, int'(event_valid), 1);
`endif
    endtask

    // Monitor: every accepted event must match the oldest expectation, and valid must drop the cycle after.
    always @(negedge clk) begin
        if (!button_reset) begin
            prev_hs <= 1'b0;
        end else begin
            if (prev_hs) check("valid_low_after_hs", int'(event_valid), 0);
            if (event_valid && event_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_event", int'({event_pressed, event_code}), -1);
                end else begin
                    check("event", int'({event_pressed, event_code}), int'(exp_q.pop_front()));
                end
                prev_hs <= 1'b1;
            end else begin
                prev_hs <= 1'b0;
            end
        end
    end

    initial begin
        int bad;
        button_reset = 1'b0;
        pins_r       = '0;
        keys_raw     = '0;
        event_ready  = 1'b1;
        #12;
        check("rst_pins_k", int'(pins_k), 0);
        check("rst_valid", int'(event_valid), 0);
        check("rst_code", int'(event_code), 0);
        check("rst_pressed", int'(event_pressed), 0);
        cyc(2);
        button_reset = 1'b1;

        // Single key 9 (r2,k1) press and release
        pins_r = 11'b100;
        set_key(9, 1'b1, 1'b1);
        cyc(30);
        check("k9_pins_k", int'(pins_k), 4'b0010);
        pins_r = '0;
        cyc(2);
        check("r0_pins_k", int'(pins_k), 0);
        wait_drain("k9_press_drain");
        pins_r = 11'b100;
        set_key(9, 1'b0, 1'b1);
        cyc(30);
        check("k9_rel_pins_k", int'(pins_k), 0);
        wait_drain("k9_rel_drain");

        // Bounce: toggle once per tick period, debounce never agrees four times
        bad = 0;
        for (int t = 0; t < 12; t++) begin
            keys_raw[9] = ~keys_raw[9];
            for (int c = 0; c < 4; c++) begin
                cyc(1);
                if (pins_k != 0) bad++;
            end
        end
        cyc(30);
        check("bounce_pins_k_glitches", bad, 0);
        check("bounce_pins_k", int'(pins_k), 0);

        // Backpressure: key 3 pending, key 40 pressed behind it
        event_ready = 1'b0;
        set_key(3, 1'b1, 1'b1);
        wait_valid("k3_valid");
        set_key(40, 1'b1, 1'b1);
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            cyc(1);
`ifdef KEY_MATRIX_EVENT_EN
            if (!event_valid || event_code != 3 || !event_pressed) bad++;
`else
            if (event_valid) bad++;
`endif
        end
        check("hold_stable", bad, 0);
        event_ready = 1'b1;
        wait_drain("k3_k40_drain");
        set_key(3, 1'b0, 1'b1);
        wait_drain("k3_rel_drain");
        set_key(40, 1'b0, 1'b1);
        wait_drain("k40_rel_drain");

        // Two strobes high: OR of rows 0 and 2
        set_key(0, 1'b1, 1'b1);
        wait_drain("k0_drain");
        set_key(9, 1'b1, 1'b1);
        wait_drain("k9b_drain");
        cyc(30);
        pins_r = 11'b00000000101;
        cyc(2);
        check("rows02_pins_k", int'(pins_k), 4'b0011);
        pins_r = 11'b00000000001;
        cyc(2);
        check("row0_pins_k", int'(pins_k), 4'b0001);
        set_key(0, 1'b0, 1'b1);
        wait_drain("k0_rel_drain");
        set_key(9, 1'b0, 1'b1);
        wait_drain("k9b_rel_drain");
        cyc(30);

        // Reset while an event is held
        pins_r = 11'b100;
        event_ready = 1'b0;
        set_key(9, 1'b1, 1'b1);
        wait_valid("k9c_valid");
        cyc(10);
        button_reset = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_pins_k", int'(pins_k), 0);
        check("midrst_valid", int'(event_valid), 0);
        check("midrst_code", int'(event_code), 0);
        check("midrst_pressed", int'(event_pressed), 0);
        cyc(3);
        button_reset = 1'b1;
        push_exp(9, 1'b1);
        event_ready = 1'b1;
        wait_drain("k9_rereport_drain");
        cyc(30);
        check("k9_after_rst_pins_k", int'(pins_k), 4'b0010);
        cyc(5);
        check("final_queue", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
